// File: rtl/bist_session_ctrl.sv
// Multi-session BIST sequencer: runs N_SESSIONS INIT/RUN/CMP passes over the TPG/MISR
// datapath and collects a per-session signature fail map plus an overall verdict.
module bist_session_ctrl #(
    parameter int unsigned                  N_SESSIONS   = 4,
    parameter int unsigned                  NCYCLES      = 650,
    parameter int unsigned                  SIG_W        = 16,
    parameter logic [N_SESSIONS*SIG_W-1:0]  GOLDEN       = '0,
    parameter bit                           STOP_ON_FAIL = 1'b0,
    localparam int unsigned                 SESS_W       = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1,
    localparam int unsigned                 CNT_W        = $clog2(NCYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIG_W-1:0]      misr_sig,
    output logic                  tpg_init,
    output logic                  misr_init,
    output logic                  tpg_en,
    output logic                  misr_en,
    output logic [SESS_W-1:0]     session,
    output logic                  busy,
    output logic                  bist_end,
    output logic                  pass_fail,
    output logic [N_SESSIONS-1:0] fail_map
);

    typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    start_q;
    logic                    start_armed;
    logic                    start_edge;
    logic                    active;
    logic                    mismatch;
    logic                    last_sess;
    logic [CNT_W-1:0]        cnt;
    logic [SIG_W-1:0]        golden_cur;
    logic [N_SESSIONS-1:0]   fail_map_upd;

    // start_armed stays low for the first clock after reset so that a start level
    // already high at release is absorbed into start_q instead of looking like an edge.
    always_comb begin
        start_edge   = start & ~start_q & start_armed;
        active       = (state == INIT) || (state == RUN) || (state == CMP);
        golden_cur   = GOLDEN[32'(session)*SIG_W +: SIG_W];
        mismatch     = (misr_sig != golden_cur);
        last_sess    = (session == SESS_W'(N_SESSIONS - 1));
        fail_map_upd = fail_map;
        fail_map_upd[session] = mismatch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tpg_init  = 1'b0;
        misr_init = 1'b0;
        tpg_en    = 1'b0;
        misr_en   = 1'b0;
        busy      = 1'b0;
        bist_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge && !abort) state_nxt = INIT;
            end
            INIT: begin
                tpg_init  = 1'b1;
                misr_init = 1'b1;
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                tpg_en  = 1'b1;
                misr_en = 1'b1;
                busy    = 1'b1;
                if (cnt == CNT_W'(NCYCLES - 1)) state_nxt = CMP;
            end
            CMP: begin
                busy      = 1'b1;
                state_nxt = (last_sess || (STOP_ON_FAIL && mismatch)) ? DONE : INIT;
            end
            DONE: begin
                bist_end = 1'b1;
                if (start_edge && !abort) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
        if (active && abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            cnt         <= '0;
            session     <= '0;
            fail_map    <= '0;
            pass_fail   <= 1'b0;
        end else begin
            start_q     <= start;
            start_armed <= 1'b1;
            if (!active && start_edge && !abort) begin
                session   <= '0;
                fail_map  <= '0;
                pass_fail <= 1'b0;
            end else if (active && abort) begin
                pass_fail <= 1'b0;
            end else begin
                case (state)
                    INIT: cnt <= '0;
                    RUN:  cnt <= cnt + 1'b1;
                    CMP: begin
                        fail_map <= fail_map_upd;
                        if (state_nxt == DONE) begin
                            pass_fail <= ~|fail_map_upd;
                        end else begin
                            session <= session + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Bench for bist_session_ctrl: vector table, directed corner sequences and a random
// phase checked against a session/offset reference model (one DUT per STOP_ON_FAIL value).
module tb_bist_session_ctrl;

    localparam int NS  = 2;
    localparam int NC  = 4;
    localparam int SW  = 8;
    localparam int PER = NC + 2;
    localparam logic [NS*SW-1:0] GOLD = {8'h5A, 8'hA5};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] misr_sig = '0;

    logic d0_tpg_init, d0_misr_init, d0_tpg_en, d0_misr_en, d0_busy, d0_bist_end, d0_pass_fail;
    logic d1_tpg_init, d1_misr_init, d1_tpg_en, d1_misr_en, d1_busy, d1_bist_end, d1_pass_fail;
    logic [0:0]    d0_session, d1_session;
    logic [NS-1:0] d0_fail_map, d1_fail_map;
    logic [9:0]    o0, o1;

    bist_session_ctrl #(.N_SESSIONS(NS), .NCYCLES(NC), .SIG_W(SW), .GOLDEN(GOLD), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .misr_sig(misr_sig),
        .tpg_init(d0_tpg_init), .misr_init(d0_misr_init), .tpg_en(d0_tpg_en), .misr_en(d0_misr_en),
        .session(d0_session), .busy(d0_busy), .bist_end(d0_bist_end), .pass_fail(d0_pass_fail),
        .fail_map(d0_fail_map)
    );

    bist_session_ctrl #(.N_SESSIONS(NS), .NCYCLES(NC), .SIG_W(SW), .GOLDEN(GOLD), .STOP_ON_FAIL(1'b1)) dut_stop (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .misr_sig(misr_sig),
        .tpg_init(d1_tpg_init), .misr_init(d1_misr_init), .tpg_en(d1_tpg_en), .misr_en(d1_misr_en),
        .session(d1_session), .busy(d1_busy), .bist_end(d1_bist_end), .pass_fail(d1_pass_fail),
        .fail_map(d1_fail_map)
    );

    assign o0 = {d0_tpg_init, d0_misr_init, d0_tpg_en, d0_misr_en, d0_busy, d0_bist_end,
                 d0_pass_fail, d0_session, d0_fail_map};
    assign o1 = {d1_tpg_init, d1_misr_init, d1_tpg_en, d1_misr_en, d1_busy, d1_bist_end,
                 d1_pass_fail, d1_session, d1_fail_map};

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Vector table: inputs before a clock edge, expected outputs after it.
    typedef struct {
        bit          start;
        logic [7:0]  misr;
        logic [9:0]  exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit s, input logic [7:0] m, input logic [7:0] o, input logic [1:0] f);
        vec_t v;
        v.start = s;
        v.misr  = m;
        v.exp   = {o, f};
        tbl.push_back(v);
    endtask

    // Reference model: a run is a position t counted from the start edge; session and
    // phase (INIT / RUN / CMP) follow from t by division by the per-session period.
    typedef struct {
        bit        active;
        bit        done;
        bit        pf;
        int        t;
        int        sess;
        bit [1:0]  fmap;
    } mdl_t;

    logic [7:0] gold_tab [NS] = '{8'hA5, 8'h5A};

    function automatic mdl_t mreset();
        mdl_t m;
        m.active = 0; m.done = 0; m.pf = 0; m.t = 0; m.sess = 0; m.fmap = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit stop, input bit edge_s,
                                   input bit ab, input logic [7:0] sig);
        mdl_t r;
        bit   mis;
        r = m;
        if (m.active) begin
            if (ab) begin
                r.active = 0;
                r.done   = 0;
                r.pf     = 0;
            end else if (m.t % PER == PER - 1) begin
                mis = (sig != gold_tab[m.sess]);
                r.fmap[m.sess] = mis;
                if (m.sess == NS - 1 || (stop && mis)) begin
                    r.active = 0;
                    r.done   = 1;
                    r.pf     = (r.fmap == 2'b00);
                end else begin
                    r.t    = m.t + 1;
                    r.sess = r.t / PER;
                end
            end else begin
                r.t = m.t + 1;
            end
        end else if (edge_s && !ab) begin
            r.active = 1; r.done = 0; r.pf = 0; r.t = 0; r.sess = 0; r.fmap = '0;
        end
        return r;
    endfunction

    function automatic logic [9:0] mexp(input mdl_t m);
        int pos;
        pos = m.t % PER;
        if (m.active)
            return {pos == 0, pos == 0, (pos >= 1 && pos <= NC), (pos >= 1 && pos <= NC),
                    1'b1, 1'b0, 1'b0, 1'(m.sess), m.fmap};
        return {4'b0000, 1'b0, m.done, m.done & m.pf, 1'(m.sess), m.fmap};
    endfunction

    // Pulses start, then clocks until bist_end of the chosen DUT; n = edges from the
    // start edge to DONE. misr shows m0 up to the first compare, m1 afterwards.
    task automatic run_to_end(input bit which, input logic [7:0] m0, input logic [7:0] m1,
                              input bit extra, output int n);
        n = 0;
        while (n < 40) begin
            start    = (n == 0) || (extra && n == 4);
            misr_sig = (n <= PER) ? m0 : m1;
            tick();
            if (which ? d1_bist_end : d0_bist_end) break;
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        int   n;
        bit   sq, armed, e;
        mdl_t m0, m1;

        // Passing run, then a run with a session-1 mismatch
        add(1, 8'h00, 8'b11001000, 2'b00);
        add(1, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00001000, 2'b00);
        add(0, 8'hA5, 8'b11001001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00001001, 2'b00);
        add(0, 8'h5A, 8'b00000111, 2'b00);
        add(0, 8'h00, 8'b00000111, 2'b00);
        add(1, 8'h00, 8'b11001000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00111000, 2'b00);
        add(0, 8'h00, 8'b00001000, 2'b00);
        add(0, 8'hA5, 8'b11001001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00111001, 2'b00);
        add(0, 8'h00, 8'b00001001, 2'b00);
        add(0, 8'h00, 8'b00000101, 2'b10);
        add(0, 8'h00, 8'b00000101, 2'b10);

        repeat (3) @(negedge clk);
        check("reset_d0", o0, 10'h000);
        check("reset_d1", o1, 10'h000);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < tbl.size(); i++) begin
            start    = tbl[i].start;
            misr_sig = tbl[i].misr;
            tick();
            check($sformatf("vec%0d", i), o0, tbl[i].exp);
        end
        start = 1'b0;
        tick();

        // STOP_ON_FAIL ends at the first failing session
        run_to_end(1'b1, 8'hFF, 8'hFF, 1'b0, n);
        check("stop_latency", n, 6);
        check("stop_session", d1_session, 0);
        check("stop_fail_map", d1_fail_map, 2'b01);
        check("stop_pass_fail", d1_pass_fail, 0);
        check("nostop_still_busy", d0_busy, 1);
        repeat (8) tick();
        check("nostop_fail_map", {d0_bist_end, d0_pass_fail, d0_fail_map}, 4'b1011);

        // Abort on the third RUN cycle of session 1
        start = 1'b1;
        tick();
        start    = 1'b0;
        misr_sig = 8'hFF;
        repeat (9) tick();
        check("abort_pre", {d0_tpg_en, d0_session}, 2'b11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {d0_busy, d0_bist_end, d0_tpg_en, d0_misr_en, d0_pass_fail}, 5'b00000);
        check("abort_partial_map", d0_fail_map, 2'b01);
        run_to_end(1'b0, 8'hA5, 8'h5A, 1'b0, n);
        check("rerun_latency", n, 12);
        check("rerun_result", {d0_pass_fail, d0_fail_map}, 3'b100);

        // Start held through reset release; extra edge mid-RUN
        start = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("held_start_no_run", {d0_busy, d1_busy}, 2'b00);
        start = 1'b0;
        tick();
        run_to_end(1'b0, 8'hA5, 8'h5A, 1'b1, n);
        check("extra_edge_latency", n, 12);
        check("extra_edge_pass", d0_pass_fail, 1);

        // Async reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_reset_run", d0_tpg_en, 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_d0", o0, 10'h000);
        check("async_reset_d1", o1, 10'h000);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        run_to_end(1'b0, 8'hA5, 8'h5A, 1'b0, n);
        check("post_reset_latency", n, 12);
        check("post_reset_pass", d0_pass_fail, 1);

        // Random phase against the reference model
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        reset = 1'b0;
        m0 = mreset();
        m1 = mreset();
        sq = 0;
        armed = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 99) < 20) start = ~start;
            abort = ($urandom_range(0, 39) == 0);
            if (m0.active && (m0.t % PER == PER - 1) && $urandom_range(0, 3) != 0)
                misr_sig = gold_tab[m0.sess];
            else if (m1.active && (m1.t % PER == PER - 1) && $urandom_range(0, 1) != 0)
                misr_sig = gold_tab[m1.sess];
            else
                misr_sig = 8'($urandom());
            @(posedge clk);
            e  = start & ~sq & armed;
            m0 = mstep(m0, 1'b0, e, abort, misr_sig);
            m1 = mstep(m1, 1'b1, e, abort, misr_sig);
            sq = start;
            armed = 1;
            @(negedge clk);
            check("rand_nostop", o0, mexp(m0));
            check("rand_stop", o1, mexp(m1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
